// File: rtl/bsg_downstream_pkg.sv
// Shared types and defaults for the downstream receive-buffer read side.
package bsg_downstream_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int PTR_W_DEF  = 7;
  localparam int HALF_W_DEF = 16;

  typedef enum logic [2:0] {
    LO,
    LO_CAP,
    HI,
    HI_CAP,
    OUT
  } rd_state_e;

  // Entries between two wrap-bit pointers, modulo 2**ptr_w.
  function automatic logic [31:0] ptr_occupancy(input logic [31:0] wptr,
                                                input logic [31:0] rptr,
                                                input int          ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (wptr - rptr) & mask;
  endfunction

endpackage

// File: rtl/bsg_token_batcher.sv
// Counts freed buffer entries and emits a one-cycle credit pulse every
// TOKEN_BATCH entries.
module bsg_token_batcher #(
  parameter int TOKEN_BATCH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic free_i,
  output logic token_o
);

  localparam int CNT_W = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOKEN_BATCH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             token_q, token_d;

  always_comb begin
    cnt_d   = cnt_q;
    token_d = 1'b0;
    if (free_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        token_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      token_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      token_q <= token_d;
    end
  end

  assign token_o = token_q;

endmodule

// File: rtl/bsg_downstream_rd_ctrl.sv
// Pops 16-bit receive-buffer entries in lo/hi pairs, hands 32-bit words to the
// core over valid/ready, and returns credits to the off-chip sender.
module bsg_downstream_rd_ctrl
  import bsg_downstream_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int PTR_W       = ADDR_W + 1,
  parameter int HALF_W      = HALF_W_DEF,
  parameter int TOKEN_BATCH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PTR_W-1:0]    wptr_i,
  output logic                buf_rd_en_o,
  output logic [ADDR_W-1:0]   buf_addr_o,
  input  logic [HALF_W-1:0]   buf_data_i,
  output logic [2*HALF_W-1:0] core_data_o,
  output logic                core_valid_o,
  input  logic                core_ready_i,
  output logic [PTR_W-1:0]    rptr_o,
  output logic                io_token_o,
  output logic                err_o
);

  rd_state_e           state_q, state_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [HALF_W-1:0]   lo_q, lo_d;
  logic [2*HALF_W-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                empty, rd_fire, capture;
  logic [31:0]         occupancy;

  always_comb begin
    empty     = (wptr_i == rptr_q);
    state_d   = state_q;
    lo_d      = lo_q;
    data_d    = data_q;
    valid_d   = valid_q;
    rd_fire   = 1'b0;
    capture   = 1'b0;
    case (state_q)
      LO: begin
        if (!empty) begin
          rd_fire = 1'b1;
          state_d = LO_CAP;
        end
      end
      LO_CAP: begin
        lo_d    = buf_data_i;
        capture = 1'b1;
        if (!empty) begin
          rd_fire = 1'b1;
          state_d = HI_CAP;
        end else begin
          state_d = HI;
        end
      end
      HI: begin
        if (!empty) begin
          rd_fire = 1'b1;
          state_d = HI_CAP;
        end
      end
      HI_CAP: begin
        data_d  = {buf_data_i, lo_q};
        valid_d = 1'b1;
        capture = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        // The next lo read overlaps the accept cycle to sustain one word per 3 cycles.
        if (core_ready_i) begin
          valid_d = 1'b0;
          if (!empty) begin
            rd_fire = 1'b1;
            state_d = LO_CAP;
          end else begin
            state_d = LO;
          end
        end
      end
      default: state_d = LO;
    endcase
    rptr_d    = rptr_q + PTR_W'(rd_fire);
    occupancy = ptr_occupancy(32'(wptr_i), 32'(rptr_q), PTR_W);
    err_d     = err_q | (occupancy > (32'd1 << ADDR_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LO;
      rptr_q  <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  bsg_token_batcher #(
    .TOKEN_BATCH(TOKEN_BATCH)
  ) u_token_batcher (
    .clk    (clk),
    .rst    (rst),
    .free_i (capture),
    .token_o(io_token_o)
  );

  // Strobe is masked during reset so a stale nonzero wptr_i cannot fire a read.
  assign buf_rd_en_o  = rd_fire & ~rst;
  assign buf_addr_o   = rptr_q[ADDR_W-1:0];
  assign core_data_o  = data_q;
  assign core_valid_o = valid_q;
  assign rptr_o       = rptr_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_bsg_downstream_rd_ctrl.sv
// Directed bench for the downstream read sequencer with a synchronous-read
// buffer model behind it.
module tb_bsg_downstream_rd_ctrl;

  logic        clk;
  logic        rst;
  logic [6:0]  wptr_i;
  logic        buf_rd_en_o;
  logic [5:0]  buf_addr_o;
  logic [15:0] buf_data_i;
  logic [31:0] core_data_o;
  logic        core_valid_o;
  logic        core_ready_i;
  logic [6:0]  rptr_o;
  logic        io_token_o;
  logic        err_o;

  logic [15:0] mem [64];
  int          tests_run;
  int          tests_failed;

  bsg_downstream_rd_ctrl #(
    .TOKEN_BATCH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wptr_i      (wptr_i),
    .buf_rd_en_o (buf_rd_en_o),
    .buf_addr_o  (buf_addr_o),
    .buf_data_i  (buf_data_i),
    .core_data_o (core_data_o),
    .core_valid_o(core_valid_o),
    .core_ready_i(core_ready_i),
    .rptr_o      (rptr_o),
    .io_token_o  (io_token_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receive buffer model: registered read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (buf_rd_en_o) buf_data_i <= mem[buf_addr_o];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [6:0] wp, input logic rdy);
    @(negedge clk);
    wptr_i       = wp;
    core_ready_i = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    int          j;
    int          tok;
    int          k;
    int          n;
    int          guard;
    logic [6:0]  wp_cur;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    wptr_i       = '0;
    core_ready_i = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

    // Reset values
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("rst_rptr", 32'(rptr_o), 0);
    checkOutput("rst_data", core_data_o, 0);
    checkOutput("rst_valid", 32'(core_valid_o), 0);
    checkOutput("rst_rd_en", 32'(buf_rd_en_o), 0);
    checkOutput("rst_token", 32'(io_token_o), 0);
    checkOutput("rst_err", 32'(err_o), 0);
    rst = 1'b0;

    // 1: two entries form one word
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    applyStimulus(2, 0);
    checkOutput("t1_rd0_en", 32'(buf_rd_en_o), 1);
    checkOutput("t1_rd0_addr", 32'(buf_addr_o), 0);
    applyStimulus(2, 0);
    checkOutput("t1_rd1_en", 32'(buf_rd_en_o), 1);
    checkOutput("t1_rd1_addr", 32'(buf_addr_o), 1);
    checkOutput("t1_rptr1", 32'(rptr_o), 1);
    applyStimulus(2, 0);
    checkOutput("t1_hicap_rd_en", 32'(buf_rd_en_o), 0);
    checkOutput("t1_hicap_valid", 32'(core_valid_o), 0);
    applyStimulus(2, 1);
    checkOutput("t1_valid", 32'(core_valid_o), 1);
    checkOutput("t1_data", core_data_o, 32'h2222_1111);
    checkOutput("t1_rptr2", 32'(rptr_o), 2);
    checkOutput("t1_out_rd_en", 32'(buf_rd_en_o), 0);
    applyStimulus(2, 1);
    checkOutput("t1_valid_drop", 32'(core_valid_o), 0);

    // 2: lo only, wait in HI, then hi arrives
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;
    applyStimulus(3, 1);
    checkOutput("t2_rd_lo_addr", 32'(buf_addr_o), 2);
    checkOutput("t2_rd_lo_en", 32'(buf_rd_en_o), 1);
    applyStimulus(3, 1);
    checkOutput("t2_locap_no_rd", 32'(buf_rd_en_o), 0);
    applyStimulus(3, 1);
    checkOutput("t2_hi_no_rd", 32'(buf_rd_en_o), 0);
    checkOutput("t2_ready_ignored", 32'(core_valid_o), 0);
    applyStimulus(3, 1);
    checkOutput("t2_hi_wait", 32'(buf_rd_en_o), 0);
    applyStimulus(4, 1);
    checkOutput("t2_rd_hi_en", 32'(buf_rd_en_o), 1);
    checkOutput("t2_rd_hi_addr", 32'(buf_addr_o), 3);
    applyStimulus(4, 1);
    checkOutput("t2_hicap_valid", 32'(core_valid_o), 0);
    applyStimulus(4, 1);
    checkOutput("t2_valid", 32'(core_valid_o), 1);
    checkOutput("t2_data", core_data_o, 32'h4444_3333);
    checkOutput("t2_token", 32'(io_token_o), 1);
    applyStimulus(4, 1);
    checkOutput("t2_token_clear", 32'(io_token_o), 0);
    checkOutput("t2_valid_drop", 32'(core_valid_o), 0);

    // 3: backpressure with 6 entries pending
    for (int i = 4; i < 10; i++) mem[i] = 16'(16'h5000 + i);
    applyStimulus(10, 0);
    checkOutput("t3_rd_addr4", 32'(buf_addr_o), 4);
    applyStimulus(10, 0);
    checkOutput("t3_rd_addr5", 32'(buf_addr_o), 5);
    applyStimulus(10, 0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(10, 0);
      checkOutput("t3_hold_data", core_data_o, 32'h5005_5004);
      checkOutput("t3_hold_rptr", 32'(rptr_o), 6);
      checkOutput("t3_hold_no_rd", 32'(buf_rd_en_o), 0);
    end
    applyStimulus(10, 1);
    checkOutput("t3_accept_valid", 32'(core_valid_o), 1);
    checkOutput("t3_accept_rd_en", 32'(buf_rd_en_o), 1);
    checkOutput("t3_accept_addr", 32'(buf_addr_o), 6);
    applyStimulus(10, 1);
    checkOutput("t3_post_valid", 32'(core_valid_o), 0);
    checkOutput("t3_post_addr", 32'(buf_addr_o), 7);
    applyStimulus(10, 1);
    applyStimulus(10, 1);
    checkOutput("t3_w2_data", core_data_o, 32'h5007_5006);
    checkOutput("t3_w2_token", 32'(io_token_o), 1);
    applyStimulus(10, 1);
    applyStimulus(10, 1);
    applyStimulus(10, 1);
    checkOutput("t3_w3_data", core_data_o, 32'h5009_5008);
    checkOutput("t3_w3_token", 32'(io_token_o), 0);
    applyStimulus(10, 1);
    checkOutput("t3_end_rptr", 32'(rptr_o), 10);
    checkOutput("t3_end_valid", 32'(core_valid_o), 0);

    // 4: stream 130 entries from a fresh reset, pointer wraps
    rst = 1'b1;
    applyStimulus(0, 1);
    rst = 1'b0;
    j      = 0;
    tok    = 0;
    k      = 0;
    wp_cur = '0;
    while (k < 130) begin
      n = (130 - k > 32) ? 32 : 130 - k;
      for (int i = 0; i < n; i++) mem[(k + i) % 64] = 16'(16'hA000 + k + i);
      wp_cur = 7'(wp_cur + 7'(n));
      k      = k + n;
      guard  = 0;
      do begin
        applyStimulus(wp_cur, 1);
        if (core_valid_o && core_ready_i) begin
          checkOutput("t4_word", core_data_o,
                      {16'(16'hA000 + 2 * j + 1), 16'(16'hA000 + 2 * j)});
          j++;
        end
        if (io_token_o) tok++;
        guard++;
      end while (rptr_o != wp_cur && guard < 200);
      checkOutput("t4_chunk_drain", 32'(rptr_o), 32'(wp_cur));
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus(wp_cur, 1);
      if (core_valid_o && core_ready_i) begin
        checkOutput("t4_word", core_data_o,
                    {16'(16'hA000 + 2 * j + 1), 16'(16'hA000 + 2 * j)});
        j++;
      end
      if (io_token_o) tok++;
    end
    checkOutput("t4_word_count", 32'(j), 65);
    checkOutput("t4_token_count", 32'(tok), 32);
    checkOutput("t4_rptr_wrap", 32'(rptr_o), 2);
    checkOutput("t4_err", 32'(err_o), 0);

    // 5: reset while in LO_CAP
    mem[2] = 16'hBEEF;
    mem[3] = 16'hCAFE;
    applyStimulus(4, 1);
    checkOutput("t5_rd_addr2", 32'(buf_addr_o), 2);
    applyStimulus(4, 1);
    checkOutput("t5_locap_addr", 32'(buf_addr_o), 3);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_rptr", 32'(rptr_o), 0);
    checkOutput("t5_rst_rd_en", 32'(buf_rd_en_o), 0);
    checkOutput("t5_rst_valid", 32'(core_valid_o), 0);
    checkOutput("t5_rst_data", core_data_o, 0);
    checkOutput("t5_rst_token", 32'(io_token_o), 0);
    applyStimulus(0, 1);
    checkOutput("t5_rst_hold_rptr", 32'(rptr_o), 0);
    rst = 1'b0;
    mem[0] = 16'h0A00;
    mem[1] = 16'h0A01;
    mem[2] = 16'h0A02;
    mem[3] = 16'h0A03;
    applyStimulus(4, 1);
    checkOutput("t5_refill_en", 32'(buf_rd_en_o), 1);
    checkOutput("t5_refill_addr", 32'(buf_addr_o), 0);
    applyStimulus(4, 1);
    applyStimulus(4, 1);
    applyStimulus(4, 1);
    checkOutput("t5_w1_data", core_data_o, 32'h0A01_0A00);
    checkOutput("t5_w1_token", 32'(io_token_o), 0);
    applyStimulus(4, 1);
    applyStimulus(4, 1);
    applyStimulus(4, 1);
    checkOutput("t5_w2_data", core_data_o, 32'h0A03_0A02);
    checkOutput("t5_w2_token", 32'(io_token_o), 1);
    applyStimulus(4, 0);
    checkOutput("t5_end_token", 32'(io_token_o), 0);
    checkOutput("t5_end_rptr", 32'(rptr_o), 4);

    // 6: overrun detection; occupancy of exactly 64 is legal
    applyStimulus(68, 0);
    checkOutput("t6_full_rd_addr", 32'(buf_addr_o), 4);
    applyStimulus(68, 0);
    applyStimulus(68, 0);
    applyStimulus(68, 0);
    checkOutput("t6_stall_rptr", 32'(rptr_o), 6);
    checkOutput("t6_full_no_err", 32'(err_o), 0);
    applyStimulus(71, 0);
    checkOutput("t6_err_registered", 32'(err_o), 0);
    applyStimulus(71, 0);
    checkOutput("t6_err_set", 32'(err_o), 1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(6, 0);
      checkOutput("t6_err_sticky", 32'(err_o), 1);
    end
    rst = 1'b1;
    #1;
    checkOutput("t6_err_rst", 32'(err_o), 0);
    applyStimulus(0, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
